// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA datapath arithmetic blocks.
// Holds the serial subtractor state encoding and a counter-width helper.
package rsa_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // At least one bit, even when a single digit covers the whole operand.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle between the controlling FSM and serial_subtractor.
// Handshake: start is sampled only while the unit is not busy (IDLE or DONE);
// a and b are captured on that accepting edge. done is a one-cycle pulse that
// qualifies diff/borrow/result, which then hold until the next accept or reset.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, result
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, result
  );

endinterface

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit borrow-ripple chain of full-subtractor cells.
// Computes d = x - y - bin and the borrow out of the top bit.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  always_comb begin
    logic bc;
    bc = bin;
    d  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ bc;
      // Borrow when x is 0 and y is 1, or when x == y and a borrow is pending.
      bc   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bc);
    end
    bout = bc;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b with borrow chain, LSB digit first, plus the
// conditional reduction result (a >= b) ? a - b : a for modular correction.
module serial_subtractor
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus,
  output sub_state_t          state_o
);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
  end

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bchain_q, bchain_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] x_slice;
  logic [DIGIT-1:0] y_slice;
  logic [DIGIT-1:0] dig_d;
  logic             dig_bout;

  assign x_slice = a_q[cnt_q*DIGIT +: DIGIT];
  assign y_slice = b_q[cnt_q*DIGIT +: DIGIT];

  digit_subtractor #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x    (x_slice),
    .y    (y_slice),
    .bin  (bchain_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    bchain_d = bchain_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    result_d = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          cnt_d    = '0;
          bchain_d = 1'b0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        diff_d[cnt_q*DIGIT +: DIGIT] = dig_d;
        bchain_d = dig_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final digit: its borrow-out is the borrow of the whole subtraction.
          cnt_d    = '0;
          borrow_d = dig_bout;
          result_d = dig_bout ? a_q : diff_d;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bchain_q <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bchain_q <= bchain_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.result = result_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: two instances (DIGIT=4 and DIGIT=1) share one
// stimulus stream; expected results and done cycles come from a plain-arithmetic model.
module tb_serial_subtractor;
  import rsa_pkg::*;

  localparam int W      = 8;
  localparam int NDIG_A = W / 4;
  localparam int NDIG_B = W / 1;
  localparam int EW     = 32 + W + 1 + W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  sub_state_t   state_a, state_b;

  int cyc    = 0;
  int rem_a  = 0;
  int rem_b  = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  logic rst_seen = 1'b0;

  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) if_a ();
  serial_subtractor_if #(.WIDTH(W)) if_b ();

  assign if_a.start = start;
  assign if_a.a     = a_in;
  assign if_a.b     = b_in;
  assign if_b.start = start;
  assign if_b.a     = a_in;
  assign if_b.b     = b_in;

  serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_a),
    .state_o (state_a)
  );

  serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_b),
    .state_o (state_b)
  );

  // Reference: unsigned subtraction modulo 2^W, borrow when a < b.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input int done_at);
    logic [W-1:0] d;
    logic         br;
    logic [W-1:0] r;
    logic [31:0]  t;
    d  = W'((a + (2**W - b)) % (2**W));
    br = (a < b);
    r  = br ? a : d;
    t  = done_at;
    return {t, r, br, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_step(input string tag, input logic busy, input logic done,
                          input logic [W-1:0] diff, input logic borrow,
                          input logic [W-1:0] result, input int rem,
                          input logic have, input logic [EW-1:0] e);
    logic [W-1:0] e_diff;
    logic         e_borrow;
    logic [W-1:0] e_result;
    e_diff   = e[W-1:0];
    e_borrow = e[W];
    e_result = e[2*W:W+1];
    check({tag, "_busy"}, 32'(busy), 32'(rem > 0));
    check({tag, "_done"}, 32'(done), 32'(have));
    if (have && done) begin
      check({tag, "_diff"},   32'(diff),   32'(e_diff));
      check({tag, "_borrow"}, 32'(borrow), 32'(e_borrow));
      check({tag, "_result"}, 32'(result), 32'(e_result));
    end
    if (rst_seen) begin
      check({tag, "_rst_diff"},   32'(diff),   32'd0);
      check({tag, "_rst_borrow"}, 32'(borrow), 32'd0);
      check({tag, "_rst_result"}, 32'(result), 32'd0);
    end
  endtask

  // Model: a request is accepted when the unit is not mid-operation.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    if (rst) begin
      rem_a <= 0;
      exp_qa.delete();
    end else if (rem_a == 0) begin
      if (start) begin
        exp_qa.push_back(model(a_in, b_in, cyc + 1 + NDIG_A));
        rem_a <= NDIG_A;
      end
    end else begin
      rem_a <= rem_a - 1;
    end
    if (rst) begin
      rem_b <= 0;
      exp_qb.delete();
    end else if (rem_b == 0) begin
      if (start) begin
        exp_qb.push_back(model(a_in, b_in, cyc + 1 + NDIG_B));
        rem_b <= NDIG_B;
      end
    end else begin
      rem_b <= rem_b - 1;
    end
  end

  always @(negedge clk) begin
    logic          have_a, have_b;
    logic [EW-1:0] e_a, e_b;
    if (cyc > 0) begin
      have_a = 1'b0;
      have_b = 1'b0;
      e_a    = '0;
      e_b    = '0;
      if (exp_qa.size() > 0) begin
        e_a = exp_qa[0];
        if (int'(e_a[EW-1 -: 32]) == cyc) begin
          have_a = 1'b1;
          void'(exp_qa.pop_front());
        end
      end
      if (exp_qb.size() > 0) begin
        e_b = exp_qb[0];
        if (int'(e_b[EW-1 -: 32]) == cyc) begin
          have_b = 1'b1;
          void'(exp_qb.pop_front());
        end
      end
      mon_step("d4", if_a.busy, if_a.done, if_a.diff, if_a.borrow, if_a.result,
               rem_a, have_a, e_a);
      mon_step("d1", if_b.busy, if_b.done, if_b.diff, if_b.borrow, if_b.result,
               rem_b, have_b, e_b);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rem_a != 0 || rem_b != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rem_a != 0 || rem_b != 0) check("idle_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    wait_idle();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op(8'hC8, 8'h37);
    op(8'h37, 8'hC8);
    op(8'hA5, 8'hA5);
    op(8'h00, 8'h01);
    op(8'hFF, 8'h00);

    // Second start while busy, with different operands, must be ignored.
    start = 1'b1; a_in = 8'hC8; b_in = 8'h37;
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-operation: no done may follow, outputs cleared.
    start = 1'b1; a_in = 8'hC8; b_in = 8'h37;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    op(8'h5A, 8'h3C);

    // Start held high with operands changing every cycle.
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      start = ($urandom_range(0, 2) != 0);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      rst   = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    wait_idle();

    check("leftover_d4", 32'(exp_qa.size()), 32'd0);
    check("leftover_d1", 32'(exp_qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
